// File: rtl/ifd_fetch_checker.sv
// Fetch-path protocol checker: compares each IFU fetch address with the PC after CMP_DELAY edges,
// flags requests during stall, and keeps saturating counters. Define IFD_CHK_LOG_EN for the mismatch log FIFO.
module ifd_fetch_checker #(
    parameter int ADDR_WIDTH = 12,
    parameter int CMP_DELAY  = 1,
    parameter int CNT_WIDTH  = 16,
    parameter int LOG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  chk_en,
    input  logic                  clr,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] PC_value,
    input  logic                  ifu_rd_req,
    input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
    output logic                  err_mismatch,
    output logic                  err_req_stall,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  fetch_cnt,
    output logic [CNT_WIDTH-1:0]  mism_cnt,
    input  logic                  log_rd,
    output logic                  log_valid,
    output logic [ADDR_WIDTH-1:0] log_pc,
    output logic [ADDR_WIDTH-1:0] log_addr,
    output logic                  log_overflow
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [2:0] DLY_INIT = 3'((CMP_DELAY > 0) ? CMP_DELAY - 1 : 0);

    state_t                  state_reg, state_next;
    logic [2:0]              dly_reg, dly_next;
    logic [ADDR_WIDTH-1:0]   cap_addr_reg;
    logic                    prev_req_reg;
    logic                    err_mismatch_reg, err_req_stall_reg, err_pulse_reg;
    logic [CNT_WIDTH-1:0]    fetch_cnt_reg, mism_cnt_reg;
    logic                    fetch_event, stall_viol, do_cmp, mism_event;
    logic [ADDR_WIDTH-1:0]   cmp_addr;

    assign fetch_event = chk_en & ifu_rd_req & ~prev_req_reg;
    assign stall_viol  = chk_en & ifu_rd_req & stall;

    // Previous request level is tracked even while checking is disabled.
    always_ff @(posedge clk) begin
        if (!reset_n) prev_req_reg <= 1'b0;
        else          prev_req_reg <= ifu_rd_req;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            state_reg <= S_IDLE;
            dly_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            dly_reg   <= dly_next;
        end
    end

    // A new fetch while waiting restarts the delay and abandons the pending check.
    always_comb begin
        state_next = state_reg;
        dly_next   = dly_reg;
        if (CMP_DELAY != 0) begin
            case (state_reg)
                S_IDLE: if (fetch_event) begin
                    state_next = S_WAIT;
                    dly_next   = DLY_INIT;
                end
                S_WAIT: begin
                    if (fetch_event)        dly_next   = DLY_INIT;
                    else if (dly_reg == 0)  state_next = S_IDLE;
                    else                    dly_next   = dly_reg - 3'd1;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        do_cmp   = 1'b0;
        cmp_addr = cap_addr_reg;
        if (CMP_DELAY == 0) begin
            do_cmp   = fetch_event;
            cmp_addr = ifu_rd_addr;
        end else begin
            do_cmp = (state_reg == S_WAIT) && (dly_reg == 3'd0) && !fetch_event;
        end
        mism_event = do_cmp && (PC_value !== cmp_addr);
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cap_addr_reg      <= '0;
            err_mismatch_reg  <= 1'b0;
            err_req_stall_reg <= 1'b0;
            err_pulse_reg     <= 1'b0;
            fetch_cnt_reg     <= '0;
            mism_cnt_reg      <= '0;
        end else begin
            if (fetch_event) cap_addr_reg <= ifu_rd_addr;
            if (fetch_event && fetch_cnt_reg != '1) fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
            if (mism_event) begin
                err_mismatch_reg <= 1'b1;
                if (mism_cnt_reg != '1) mism_cnt_reg <= mism_cnt_reg + 1'b1;
            end
            if (stall_viol) err_req_stall_reg <= 1'b1;
            err_pulse_reg <= mism_event | (stall_viol & ~err_req_stall_reg);
        end
    end

    assign err_mismatch  = err_mismatch_reg;
    assign err_req_stall = err_req_stall_reg;
    assign err_pulse     = err_pulse_reg;
    assign fetch_cnt     = fetch_cnt_reg;
    assign mism_cnt      = mism_cnt_reg;

`ifdef IFD_CHK_LOG_EN
    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;

    logic [2*ADDR_WIDTH-1:0] log_mem [LOG_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]          count_reg;
    logic                    overflow_reg;
    logic                    log_full, log_empty, pop, push_ok;

    assign log_full  = (count_reg == (PTR_W+1)'(LOG_DEPTH));
    assign log_empty = (count_reg == '0);
    assign pop       = log_rd & ~log_empty;
    // When full, a simultaneous pop frees the slot the push needs.
    assign push_ok   = mism_event & (~log_full | pop);

    always_ff @(posedge clk) begin
        if (push_ok) log_mem[wr_ptr_reg] <= {PC_value, cap_addr_reg};
    end

    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_ok && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push_ok && pop) count_reg <= count_reg - 1'b1;
            if (mism_event && log_full && !pop) overflow_reg <= 1'b1;
        end
    end

    assign log_valid    = ~log_empty;
    assign log_pc       = log_empty ? '0 : log_mem[rd_ptr_reg][2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign log_addr     = log_empty ? '0 : log_mem[rd_ptr_reg][ADDR_WIDTH-1:0];
    assign log_overflow = overflow_reg;
`else
    logic unused_log;
    localparam int unused_depth = LOG_DEPTH;
    assign unused_log   = log_rd;
    assign log_valid    = 1'b0;
    assign log_pc       = '0;
    assign log_addr     = '0;
    assign log_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_ifd_fetch_checker.sv
// Self-checking bench for ifd_fetch_checker: reference counters plus a queue of expected log entries.
module tb_ifd_fetch_checker;

    localparam int AW      = 12;
    localparam int CMP_D   = 2;
    localparam int CW      = 4;
    localparam int DEPTH   = 4;
    localparam int CNT_MAX = 15;

    logic          clk = 1'b0;
    logic          reset_n, chk_en, clr, stall, ifu_rd_req, log_rd;
    logic [AW-1:0] pc_value, ifu_rd_addr;
    logic          err_mismatch, err_req_stall, err_pulse, log_valid, log_overflow;
    logic [CW-1:0] fetch_cnt, mism_cnt;
    logic [AW-1:0] log_pc, log_addr;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_fetch = 0;
    int exp_mism  = 0;
    logic exp_ovf = 1'b0;
    logic [2*AW-1:0] exp_log[$];

    always #5 clk = ~clk;

    ifd_fetch_checker #(.ADDR_WIDTH(AW), .CMP_DELAY(CMP_D), .CNT_WIDTH(CW), .LOG_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .chk_en(chk_en), .clr(clr), .stall(stall),
        .PC_value(pc_value), .ifu_rd_req(ifu_rd_req), .ifu_rd_addr(ifu_rd_addr),
        .err_mismatch(err_mismatch), .err_req_stall(err_req_stall), .err_pulse(err_pulse),
        .fetch_cnt(fetch_cnt), .mism_cnt(mism_cnt), .log_rd(log_rd), .log_valid(log_valid),
        .log_pc(log_pc), .log_addr(log_addr), .log_overflow(log_overflow)
    );

    // One fetch: request high for one edge, returns just after the compare edge.
    task automatic do_fetch(input logic [AW-1:0] pc, input logic [AW-1:0] addr);
        @(negedge clk);
        pc_value = pc; ifu_rd_addr = addr; ifu_rd_req = 1'b1;
        @(negedge clk);
        ifu_rd_req = 1'b0;
        repeat (CMP_D) @(negedge clk);
        if (exp_fetch != CNT_MAX) exp_fetch++;
        if (pc != addr) begin
            if (exp_mism != CNT_MAX) exp_mism++;
`ifdef IFD_CHK_LOG_EN
            if (exp_log.size() < DEPTH) exp_log.push_back({pc, addr});
            else exp_ovf = 1'b1;
`endif
        end
        $display("fetch pc=%o addr=%o fetch_cnt=%0d mism_cnt=%0d", pc, addr, fetch_cnt, mism_cnt);
    endtask

    task automatic do_clr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        exp_fetch = 0; exp_mism = 0; exp_ovf = 1'b0; exp_log.delete();
        $display("clr");
    endtask

    task automatic test_reset();
        reset_n = 1'b0; chk_en = 1'b1; clr = 1'b0; stall = 1'b0; ifu_rd_req = 1'b0;
        log_rd = 1'b0; pc_value = '0; ifu_rd_addr = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL reset_err_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (err_req_stall !== 1'b0) begin n_fail++; $display("FAIL reset_err_req_stall got=%b exp=0", err_req_stall); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_err_pulse got=%b exp=0", err_pulse); end
        n_checks++; if (fetch_cnt !== '0) begin n_fail++; $display("FAIL reset_fetch_cnt got=%0d exp=0", fetch_cnt); end
        n_checks++; if (mism_cnt !== '0) begin n_fail++; $display("FAIL reset_mism_cnt got=%0d exp=0", mism_cnt); end
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL reset_log_valid got=%b exp=0", log_valid); end
        n_checks++; if (log_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_log_overflow got=%b exp=0", log_overflow); end
        reset_n = 1'b1;
        $display("reset done");
    endtask

    task automatic test_match();
        do_fetch(12'o200, 12'o200);
        n_checks++; if (fetch_cnt !== CW'(exp_fetch)) begin n_fail++; $display("FAIL match_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fetch); end
        n_checks++; if (mism_cnt !== CW'(exp_mism)) begin n_fail++; $display("FAIL match_mism_cnt got=%0d exp=%0d", mism_cnt, exp_mism); end
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL match_err_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL match_err_pulse got=%b exp=0", err_pulse); end
    endtask

    task automatic test_mismatch();
        logic [2*AW-1:0] head;
        do_fetch(12'o200, 12'o201);
        n_checks++; if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL mism_err_mismatch got=%b exp=1", err_mismatch); end
        n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL mism_err_pulse_high got=%b exp=1", err_pulse); end
        n_checks++; if (mism_cnt !== CW'(exp_mism)) begin n_fail++; $display("FAIL mism_mism_cnt got=%0d exp=%0d", mism_cnt, exp_mism); end
        n_checks++; if (fetch_cnt !== CW'(exp_fetch)) begin n_fail++; $display("FAIL mism_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fetch); end
`ifdef IFD_CHK_LOG_EN
        head = exp_log.pop_front();
        n_checks++; if (log_valid !== 1'b1) begin n_fail++; $display("FAIL mism_log_valid got=%b exp=1", log_valid); end
        n_checks++; if (log_pc !== head[2*AW-1:AW]) begin n_fail++; $display("FAIL mism_log_pc got=%o exp=%o", log_pc, head[2*AW-1:AW]); end
        n_checks++; if (log_addr !== head[AW-1:0]) begin n_fail++; $display("FAIL mism_log_addr got=%o exp=%o", log_addr, head[AW-1:0]); end
        log_rd = 1'b1;
`else
        head = '0;
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL mism_log_valid got=%b exp=0", log_valid); end
        n_checks++; if ({log_pc, log_addr} !== head) begin n_fail++; $display("FAIL mism_log_data got=%o exp=0", {log_pc, log_addr}); end
`endif
        @(negedge clk);
        log_rd = 1'b0;
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL mism_err_pulse_low got=%b exp=0", err_pulse); end
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL mism_log_empty got=%b exp=0", log_valid); end
        n_checks++; if (err_mismatch !== 1'b1) begin n_fail++; $display("FAIL mism_sticky got=%b exp=1", err_mismatch); end
    endtask

    task automatic test_stall();
        do_clr();
        @(negedge clk);
        pc_value = 12'o400; ifu_rd_addr = 12'o400; ifu_rd_req = 1'b1; stall = 1'b1;
        exp_fetch++;
        @(negedge clk);
        n_checks++; if (err_req_stall !== 1'b1) begin n_fail++; $display("FAIL stall_flag got=%b exp=1", err_req_stall); end
        n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL stall_pulse got=%b exp=1", err_pulse); end
        @(negedge clk);
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL stall_second_pulse got=%b exp=0", err_pulse); end
        n_checks++; if (err_req_stall !== 1'b1) begin n_fail++; $display("FAIL stall_sticky got=%b exp=1", err_req_stall); end
        ifu_rd_req = 1'b0; stall = 1'b0;
        @(negedge clk);
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL stall_no_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (fetch_cnt !== CW'(exp_fetch)) begin n_fail++; $display("FAIL stall_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fetch); end
        $display("stall violation err_req_stall=%b", err_req_stall);
    endtask

    task automatic test_back_to_back();
        do_clr();
        @(negedge clk);
        pc_value = 12'o300; ifu_rd_addr = 12'o777; ifu_rd_req = 1'b1;
        @(negedge clk); ifu_rd_req = 1'b0;
        @(negedge clk); ifu_rd_addr = 12'o300; ifu_rd_req = 1'b1;
        @(negedge clk); ifu_rd_req = 1'b0;
        repeat (CMP_D) @(negedge clk);
        exp_fetch += 2;
        n_checks++; if (fetch_cnt !== CW'(exp_fetch)) begin n_fail++; $display("FAIL b2b_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fetch); end
        n_checks++; if (mism_cnt !== CW'(exp_mism)) begin n_fail++; $display("FAIL b2b_mism_cnt got=%0d exp=%0d", mism_cnt, exp_mism); end
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL b2b_err_mismatch got=%b exp=0", err_mismatch); end
        $display("back_to_back fetch_cnt=%0d mism_cnt=%0d", fetch_cnt, mism_cnt);
    endtask

    task automatic test_chk_en();
        do_clr();
        @(negedge clk);
        chk_en = 1'b0; pc_value = 12'o1; ifu_rd_addr = 12'o2; ifu_rd_req = 1'b1; stall = 1'b1;
        @(negedge clk); ifu_rd_req = 1'b0; stall = 1'b0;
        repeat (CMP_D) @(negedge clk);
        chk_en = 1'b1;
        n_checks++; if (fetch_cnt !== '0) begin n_fail++; $display("FAIL chk_en_fetch_cnt got=%0d exp=0", fetch_cnt); end
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL chk_en_err_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (err_req_stall !== 1'b0) begin n_fail++; $display("FAIL chk_en_err_req_stall got=%b exp=0", err_req_stall); end
        $display("chk_en=0 request ignored");
    endtask

    task automatic test_clr_abort();
        do_clr();
        @(negedge clk);
        pc_value = 12'o10; ifu_rd_addr = 12'o11; ifu_rd_req = 1'b1;
        @(negedge clk); ifu_rd_req = 1'b0; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        repeat (CMP_D) @(negedge clk);
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL clr_abort_err_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (mism_cnt !== '0) begin n_fail++; $display("FAIL clr_abort_mism_cnt got=%0d exp=0", mism_cnt); end
        n_checks++; if (fetch_cnt !== '0) begin n_fail++; $display("FAIL clr_abort_fetch_cnt got=%0d exp=0", fetch_cnt); end
        $display("clr mid-wait aborted check");
    endtask

    task automatic test_overflow();
        logic [2*AW-1:0] head;
        do_clr();
        for (int i = 0; i <= DEPTH; i++) do_fetch(12'o1000 + AW'(i), 12'o2000 + AW'(i));
        n_checks++; if (mism_cnt !== CW'(exp_mism)) begin n_fail++; $display("FAIL ovf_mism_cnt got=%0d exp=%0d", mism_cnt, exp_mism); end
        n_checks++; if (log_overflow !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag got=%b exp=%b", log_overflow, exp_ovf); end
`ifdef IFD_CHK_LOG_EN
        for (int i = 0; i < DEPTH; i++) begin
            head = exp_log.pop_front();
            n_checks++; if (log_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_pop%0d_valid got=%b exp=1", i, log_valid); end
            n_checks++; if ({log_pc, log_addr} !== head) begin n_fail++; $display("FAIL ovf_pop%0d_entry got=%o exp=%o", i, {log_pc, log_addr}, head); end
            $display("pop %0d pc=%o addr=%o", i, log_pc, log_addr);
            log_rd = 1'b1;
            @(negedge clk);
            log_rd = 1'b0;
        end
`endif
        n_checks++; if (log_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_log_drained got=%b exp=0", log_valid); end
        do_clr();
        n_checks++; if (fetch_cnt !== '0) begin n_fail++; $display("FAIL clr_fetch_cnt got=%0d exp=0", fetch_cnt); end
        n_checks++; if (mism_cnt !== '0) begin n_fail++; $display("FAIL clr_mism_cnt got=%0d exp=0", mism_cnt); end
        n_checks++; if (err_mismatch !== 1'b0) begin n_fail++; $display("FAIL clr_err_mismatch got=%b exp=0", err_mismatch); end
        n_checks++; if (log_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_log_overflow got=%b exp=0", log_overflow); end
    endtask

    task automatic test_saturate();
        do_clr();
        repeat (17) do_fetch(12'o5, 12'o5);
        n_checks++; if (fetch_cnt !== CW'(exp_fetch)) begin n_fail++; $display("FAIL sat_fetch_cnt got=%0d exp=%0d", fetch_cnt, exp_fetch); end
        n_checks++; if (fetch_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_fetch_cnt_max got=%0d exp=15", fetch_cnt); end
        n_checks++; if (mism_cnt !== '0) begin n_fail++; $display("FAIL sat_mism_cnt got=%0d exp=0", mism_cnt); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_stall();
        test_back_to_back();
        test_chk_en();
        test_clr_abort();
        test_overflow();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ifd_fetch_checker.md
# ifd_fetch_checker

Parametrised, synthesisable protocol checker for the PDP-8 instruction-fetch path, successor to the simulation-only fetch monitor. Sits beside the IFD unit and observes the Execution-unit PC, the stall line and the IFU-to-memory read request. Flags fetch-address mismatches after a configurable delay and flags requests issued during stall. Keeps saturating event counters and, optionally, a FIFO log of mismatching address pairs readable by a bench or debug port.

## Interface
- ADDR_WIDTH, 12, width of PC and fetch address
- CMP_DELAY, 1, clock edges from request capture to comparison (0..7)
- CNT_WIDTH, 16, width of event counters
- LOG_DEPTH, 4, mismatch log entries (power of two, >=2)

- clk  in  1  clock; all logic on posedge
- reset_n  in  1  reset; synchronous, active-low
- chk_en  in  1  checking enable; 0 = observe nothing
- clr  in  1  synchronous clear of counters, flags, log, FSM
- stall  in  1  Execution-unit stall
- PC_value  in  ADDR_WIDTH  Execution-unit program counter
- ifu_rd_req  in  1  IFU read request to memory
- ifu_rd_addr  in  ADDR_WIDTH  IFU read address
- err_mismatch  out  1  sticky: PC/address mismatch seen
- err_req_stall  out  1  sticky: request issued while stall=1
- err_pulse  out  1  one-cycle pulse on any new error event
- fetch_cnt  out  CNT_WIDTH  checked fetches (request rising edges)
- mism_cnt  out  CNT_WIDTH  mismatches detected
- log_rd  in  1  pop log head
- log_valid  out  1  log non-empty
- log_pc  out  ADDR_WIDTH  head entry: PC_value at comparison
- log_addr  out  ADDR_WIDTH  head entry: captured fetch address
- log_overflow  out  1  sticky: entry dropped, log full

## Operation
- Fetch event: chk_en=1 and ifu_rd_req rising (req=1, previous-cycle req=0). A held request counts once.
- On fetch event: capture ifu_rd_addr into cap_addr, increment fetch_cnt.
- FSM states IDLE, WAIT. CMP_DELAY=0: compare at the event edge against the PC_value sampled at that edge; WAIT is never entered. CMP_DELAY>=1: IDLE->WAIT with dly=CMP_DELAY-1. In WAIT, dly decrements each edge; at the edge where dly=0, compare PC_value vs cap_addr, then go to IDLE.
- New fetch event while in WAIT: pending check is abandoned; new address is captured and the delay restarts. fetch_cnt increments; abandoned check is neither compared nor counted.
- Compare uses !== semantics in sim; any X/Z bit counts as mismatch.
- Mismatch: set err_mismatch, increment mism_cnt, pulse err_pulse, push {PC_value, cap_addr} into the log.
- Stall violation: edge with chk_en=1, ifu_rd_req=1, stall=1 sets err_req_stall. err_pulse fires only on the 0->1 transition of err_req_stall.
- chk_en=0: no events, counting or flagging; an in-progress WAIT still completes its compare.
- Counters saturate at all-ones; no wrap.
- Priority: reset_n > clr > normal operation. On clr with a simultaneous error, the error is lost.
- Log: first-word-fall-through. log_pc/log_addr show the head when log_valid=1, else 0. log_rd with empty log is ignored. Push when full is dropped and sets log_overflow. Push and pop in the same cycle when full both succeed. Push and pop in the same cycle when empty: push only.

## Timing
- Reset (reset_n=0 at an edge): all outputs 0, FSM IDLE, counters 0, log empty, prev req=0.
- Event at edge E0, mismatch: err_mismatch, mism_cnt and err_pulse update at edge E(CMP_DELAY). They are visible in the cycle after that edge. err_pulse is high exactly one cycle.
- fetch_cnt visible the cycle after E0.
- Stall violation: flag visible the cycle after the offending edge.
- Log push at the mismatch edge; log_valid high the following cycle.
- Reset or clr mid-WAIT aborts the check; no flag.

## Configuration
- IFD_CHK_LOG_EN defined: mismatch log FIFO (LOG_DEPTH x 2*ADDR_WIDTH) compiled in, as described above.
- Not defined: no FIFO storage. log_valid, log_pc, log_addr and log_overflow are tied to 0 and log_rd is ignored. Ports remain; all other behaviour is unchanged.

## Test plan
- Reset, then PC_value=0o200 and req with addr 0o200 (CMP_DELAY=1) -> fetch_cnt=1, mism_cnt=0, no error flags.
- PC_value=0o200, req addr 0o201 -> err_mismatch=1 one cycle after E1, err_pulse high one cycle, mism_cnt=1, log head pc=0o200 addr=0o201.
- req=1 while stall=1 -> err_req_stall=1 next cycle; a second violation gives no further err_pulse.
- Fetch event, then a second event during WAIT with matching address -> fetch_cnt=2, mism_cnt=0.
- LOG_DEPTH+1 mismatches without log_rd -> log_overflow=1 and LOG_DEPTH entries pop in order; then clr -> all counters, flags and log 0.
- Force fetch_cnt near 2^CNT_WIDTH-1 (CNT_WIDTH=4, 17 fetches) -> holds at 15.
